// File: rtl/in_unit.sv
// IN-instruction input peripheral: stalls the core until a debounced confirm press,
// then latches the synchronized switches (zero- or sign-extended) into e_data.
module in_unit #(
    parameter int SW_W       = 16,
    parameter int DEB_CYCLES = 50000,
    parameter bit SIGN_EXT   = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_req,
    input  logic [SW_W-1:0] switches,
    input  logic            confirm_btn,
    output logic [31:0]     e_data,
    output logic            stall,
    output logic            in_done,
    output logic            wait_led
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_PRESS,
        CAPTURE,
        DONE,
        HOLD
    } state_t;

    state_t state_reg, state_next;

    logic            btn_meta_reg, btn_sync_reg;
    logic [SW_W-1:0] sw_meta_reg, sw_sync_reg;

    logic [CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic             btn_db_reg, btn_db_next;
    logic             btn_db_prev_reg;
    logic             btn_rise;

    logic [31:0] sw_ext;
    logic [31:0] e_data_reg;
    logic        capture_en;

    // Two-flop synchronizers for the asynchronous button and switch bank
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
        end else begin
            btn_meta_reg <= confirm_btn;
            btn_sync_reg <= btn_meta_reg;
            sw_meta_reg  <= switches;
            sw_sync_reg  <= sw_meta_reg;
        end
    end

    // A new level is accepted only after DEB_CYCLES consecutive differing samples
    always_comb begin
        deb_cnt_next = '0;
        btn_db_next  = btn_db_reg;
        if (btn_sync_reg != btn_db_reg) begin
            if (deb_cnt_reg == CNT_LAST) begin
                btn_db_next = ~btn_db_reg;
            end else begin
                deb_cnt_next = deb_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            deb_cnt_reg     <= '0;
            btn_db_reg      <= 1'b0;
            btn_db_prev_reg <= 1'b0;
        end else begin
            deb_cnt_reg     <= deb_cnt_next;
            btn_db_reg      <= btn_db_next;
            btn_db_prev_reg <= btn_db_reg;
        end
    end

    assign btn_rise = btn_db_reg & ~btn_db_prev_reg;

    // Bit-wise extension to 32 bits; SW_W == 32 passes straight through
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_ext
            if (gi < SW_W) begin : g_sw
                assign sw_ext[gi] = sw_sync_reg[gi];
            end else if (SIGN_EXT) begin : g_sign
                assign sw_ext[gi] = sw_sync_reg[SW_W-1];
            end else begin : g_zero
                assign sw_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        in_done    = 1'b0;
        capture_en = 1'b0;
        case (state_reg)
            IDLE: begin
                // Stall follows in_req immediately so no IN retires with stale data
                stall = in_req;
                if (in_req) begin
                    state_next = btn_db_reg ? ARM : WAIT_PRESS;
                end
            end
            ARM: begin
                stall = 1'b1;
                if (!in_req) begin
                    state_next = IDLE;
                end else if (!btn_db_reg) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                stall = 1'b1;
                if (!in_req) begin
                    state_next = IDLE;
                end else if (btn_rise) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                stall      = 1'b1;
                capture_en = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                in_done    = 1'b1;
                state_next = in_req ? HOLD : IDLE;
            end
            HOLD: begin
                // One IN, one capture: wait for control to drop the request
                if (!in_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            e_data_reg <= '0;
        end else if (capture_en) begin
            e_data_reg <= sw_ext;
        end
    end

    assign e_data   = e_data_reg;
    assign wait_led = stall;

endmodule
